// File: rtl/fetch_unit_pkg.sv
// Shared encodings, entry layout and redirect arithmetic for the fetch stage.
package fetch_unit_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'b00,
        REDIR_BRANCH = 2'b01,
        REDIR_JUMP   = 2'b10,
        REDIR_REG    = 2'b11
    } redir_e;

    typedef struct packed {
        logic [31:0]            pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] redirect_target(
        input redir_e      sel,
        input logic [31:0] base,
        input logic [31:0] imm,
        input logic [31:0] rtgt
    );
        logic [31:0] seq;
        logic [31:0] tgt;
        seq = base + 32'd4;
        tgt = seq;
        unique case (sel)
            REDIR_BRANCH: tgt = seq + (imm << 2);
            REDIR_JUMP:   tgt = {seq[31:28], 28'h0} | ((imm << 2) & 32'h0FFF_FFFC);
            REDIR_REG:    tgt = rtgt & ~32'h3;
            default:      tgt = seq;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Flushable show-ahead FIFO; used for instruction entries and in-flight PCs.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [2**PW];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = count == '0;
    assign full      = count == CW'(DEPTH);
    assign do_pop    = pop && !empty;
    // A full queue may still take a push when the head leaves this cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch: PC, variable-latency imem requests, stale-response drop,
// and a show-ahead instruction queue toward decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [31:0]            out_pc,
    input  logic [1:0]             redirect_sel,
    input  logic [31:0]            redirect_base_pc,
    input  logic [31:0]            redirect_imm,
    input  logic [31:0]            redirect_reg,
    output logic                   misaligned
);

    localparam int QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    redir_e         sel;
    logic           redirect;
    logic           accept;
    logic           resp;
    logic           drop_resp;
    logic           push;
    logic           pop;
    logic [31:0]    fetch_pc;
    logic [31:0]    target;
    logic [31:0]    resp_pc;
    logic [QCW-1:0] count;
    logic [OCW-1:0] outstanding;
    logic [OCW-1:0] drop_count;
    logic           q_full;
    logic           q_empty;
    logic           pcq_full;
    logic           pcq_empty;
    fetch_entry_t   wr_entry;
    fetch_entry_t   head;

    assign sel      = redir_e'(redirect_sel);
    assign redirect = sel != REDIR_NONE;
    assign target   = redirect_target(sel, redirect_base_pc,
                                      redirect_imm, redirect_reg);

    // Reserve queue space for every in-flight word so responses never stall.
    assign imem_req_valid = reset_n && !redirect
        && (int'(outstanding) < MAX_OUTSTANDING)
        && (int'(outstanding) + int'(count) < QUEUE_DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign resp      = imem_resp_valid && reset_n;
    assign drop_resp = resp && (redirect || drop_count != '0);
    assign push      = resp && !drop_resp;
    assign pop       = !q_empty && out_ready;

    assign wr_entry  = '{pc: resp_pc, instr: imem_resp_data};
    assign out_valid = !q_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_q (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .head_data (head),
        .count     (count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Its occupancy doubles as the outstanding-request count.
    fetch_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_pc_q (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp),
        .head_data (resp_pc),
        .count     (outstanding),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_PC;
            drop_count <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= (sel == REDIR_REG) && (redirect_reg[1:0] != 2'b00);
            if (redirect) begin
                fetch_pc   <= target;
                drop_count <= outstanding - OCW'(resp && !pcq_empty);
            end else begin
                if (accept)    fetch_pc   <= fetch_pc + 32'd4;
                if (drop_resp) drop_count <= drop_count - OCW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(imem_resp_valid && pcq_empty))
                else $error("fetch_unit: response with no request outstanding");
            assert (!(accept && pcq_full))
                else $error("fetch_unit: outstanding limit exceeded");
            assert (!(push && q_full && !pop))
                else $error("fetch_unit: instruction queue overflow");
            assert (int'(count) <= QUEUE_DEPTH)
                else $error("fetch_unit: queue count out of range");
            assert (int'(outstanding) <= MAX_OUTSTANDING)
                else $error("fetch_unit: outstanding count out of range");
        end
    end

endmodule
